glcd_frame_scanner: RTL
=======================

Name: glcd_frame_scanner

Overview:
- Upstream feeder for the KS0108-style 128x64 graphic LCD bus driver.
- Walks a 1 KiB monochrome framebuffer (2 chips x 8 pages x 64 columns, one byte per column-page).
- Issues the init, page-address, column-address and data byte stream to the bus driver over a valid/ready command handshake.
- The bus driver owns E-pulse timing. This block owns ordering and addressing only.

Parameters:
- PAGES, 8, pages per chip (8 rows each).
- COLS, 64, columns per chip.
- START_LINE, 0, display start line (0..63) written during init.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle request to refresh the whole panel.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  single-cycle pulse after the last data byte is accepted.
- fb_addr  out  10  framebuffer read address {chip, page[2:0], col[5:0]}.
- fb_rdata  in  8  framebuffer read data, valid exactly 1 cycle after fb_addr.
- cmd_valid  out  1  command/data byte offered to bus driver.
- cmd_ready  in  1  bus driver accepts the byte this cycle.
- cmd_rs  out  1  0 = instruction, 1 = display data.
- cmd_cs  out  2  one-hot chip select {cs2, cs1}.
- cmd_data  out  8  byte to write.

Behaviour:
- Reset values: busy 0, frame_done 0, cmd_valid 0, cmd_rs 0, cmd_cs 2'b01, cmd_data 8'h00, fb_addr 0, init_done flag 0, FSM in IDLE.
- Handshake:
  - A transfer occurs when cmd_valid and cmd_ready are both high.
  - Once cmd_valid rises, cmd_rs/cmd_cs/cmd_data stay stable until the transfer.
  - cmd_valid never drops without a transfer, except on reset.
- FSM states: IDLE, INIT_ON, INIT_LINE, SET_PAGE, SET_COL, FETCH, WAIT_RD, SEND, DONE.
- IDLE: frame_start accepted only here; frames requested while busy are dropped.
  - On accept: chip=0, page=0, col=0, busy=1.
  - Go to INIT_ON if init_done=0, else SET_PAGE.
- INIT_ON: send rs=0, data 8'h3F (display on).
- INIT_LINE: send rs=0, data 8'hC0 | START_LINE[5:0].
  - After transfer: if chip=0, chip=1 and return to INIT_ON.
  - Otherwise set init_done=1, chip=0, go to SET_PAGE.
  - Init runs once per reset, for both chips.
- SET_PAGE: send rs=0, data 8'hB8 | page.
- SET_COL: send rs=0, data 8'h40 (column 0).
  - The LCD auto-increments its column, so SET_COL is sent once per page.
- FETCH: drive fb_addr={chip,page,col}; go to WAIT_RD.
- WAIT_RD: capture fb_rdata into cmd_data, rs=1, raise cmd_valid, go to SEND.
- SEND: on transfer, col+1.
  - If col was COLS-1: col=0, page+1.
  - If page was PAGES-1: page=0, chip+1.
  - If chip was 1: go to DONE.
  - Otherwise go to SET_PAGE on a page wrap, else FETCH.
- DONE: frame_done=1 for one cycle, busy=0, go to IDLE.
  - frame_start in the DONE cycle is ignored.
- cmd_cs: 2'b01 while chip=0, 2'b10 while chip=1; it changes only while cmd_valid is low.
- Byte count per frame:
  - First frame: 4 init + 2x8x(2+64) = 1060 transfers.
  - Later frames: 1056 transfers.
- Throughput: with cmd_ready tied high, each data byte costs 3 cycles (FETCH, WAIT_RD, SEND).
- Counters: col 6-bit, page 3-bit, chip 1-bit. Wrap is explicit, not relying on overflow, so non-power-of-two parameters work.
- Reset mid-frame: immediate return to IDLE, cmd_valid 0, init_done 0. The next frame re-initialises.

Optional Feature:
- Macro GLCD_INVERT_EN.
- Defined: adds input invert (1 bit). When invert=1, data bytes are cmd_data = fb_rdata ^ 8'hFF. invert is sampled in WAIT_RD. Instruction bytes are unaffected.
- Undefined: no port; data passes unchanged.

Decomposition:
- Package glcd_pkg:
  - opcode constants GLCD_DISPLAY_ON 8'h3F, GLCD_SET_PAGE 8'hB8, GLCD_SET_COL 8'h40, GLCD_SET_START 8'hC0;
  - FB address width 10;
  - FSM state enum.
- One natural sub-module: glcd_addr_counter (col/page/chip counter with wrap flags page_wrap, frame_wrap). The FSM stays in the top.

Test Plan:
- Reset, frame_start pulse, cmd_ready=1, fb_rdata=col index → first 4 transfers are (cs=01,3F),(cs=01,C0),(cs=10,3F),(cs=10,C0). Then (01,B8),(01,40),(01,rs=1,00)...; 1060 transfers; frame_done 1 cycle; busy low afterwards.
- Second frame_start → no init bytes; exactly 1056 transfers; the byte after column 63 of page 0 is instruction B9.
- Random cmd_ready backpressure (50%) → cmd_rs/cmd_cs/cmd_data never change while cmd_valid=1 and cmd_ready=0; the received byte sequence matches the first test.
- frame_start pulsed mid-frame and in the DONE cycle → ignored; exactly one frame_done.
- reset_n asserted while in SEND on chip 1 page 3 → cmd_valid 0 same cycle. The next frame_start replays the init sequence.
- GLCD_INVERT_EN defined, invert=1, fb_rdata=8'hA5 → data bytes 8'h5A; instruction bytes unchanged.

Source files
------------

// File: rtl/glcd_pkg.sv
// Shared opcodes, widths and FSM encoding for the KS0108 frame scanner.
package glcd_pkg;

    localparam int FB_AW = 10;

    localparam logic [7:0] GLCD_DISPLAY_ON = 8'h3F;
    localparam logic [7:0] GLCD_SET_PAGE   = 8'hB8;
    localparam logic [7:0] GLCD_SET_COL    = 8'h40;
    localparam logic [7:0] GLCD_SET_START  = 8'hC0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_ON,
        ST_INIT_LINE,
        ST_SET_PAGE,
        ST_SET_COL,
        ST_FETCH,
        ST_WAIT_RD,
        ST_SEND,
        ST_DONE
    } glcd_state_e;

endpackage

// File: rtl/glcd_addr_counter.sv
// Column/page/chip walker for the framebuffer scan, with explicit wrap flags.
module glcd_addr_counter #(
    parameter int PAGES = 8,
    parameter int COLS  = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       set_chip,
    input  logic       inc,
    output logic [5:0] col,
    output logic [2:0] page,
    output logic       chip,
    output logic       page_wrap,
    output logic       frame_wrap
);
    import glcd_pkg::*;

    logic [5:0] col_q, col_d;
    logic [2:0] page_q, page_d;
    logic       chip_q, chip_d;
    logic       last_page;

    assign page_wrap  = (col_q == 6'(COLS - 1));
    assign last_page  = (page_q == 3'(PAGES - 1));
    assign frame_wrap = page_wrap && last_page && chip_q;

    always_comb begin
        col_d  = col_q;
        page_d = page_q;
        chip_d = chip_q;
        if (clr) begin
            col_d  = '0;
            page_d = '0;
            chip_d = 1'b0;
        end else if (set_chip) begin
            col_d  = '0;
            page_d = '0;
            chip_d = 1'b1;
        end else if (inc) begin
            // Compare against the parameter bounds so non-power-of-two sizes wrap correctly
            if (page_wrap) begin
                col_d = '0;
                if (last_page) begin
                    page_d = '0;
                    chip_d = ~chip_q;
                end else begin
                    page_d = page_q + 3'd1;
                end
            end else begin
                col_d = col_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q  <= '0;
            page_q <= '0;
            chip_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            page_q <= page_d;
            chip_q <= chip_d;
        end
    end

    assign col  = col_q;
    assign page = page_q;
    assign chip = chip_q;

endmodule

// File: rtl/glcd_frame_scanner.sv
// Walks the framebuffer and emits init/page/column/data bytes to the KS0108 bus driver.
// Optional build macro GLCD_INVERT_EN adds an `invert` input that complements data bytes.
module glcd_frame_scanner #(
    parameter int PAGES      = 8,
    parameter int COLS       = 64,
    parameter int START_LINE = 0
) (
`ifdef GLCD_INVERT_EN
    input  logic                      invert,
`endif
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_start,
    output logic                      busy,
    output logic                      frame_done,
    output logic [glcd_pkg::FB_AW-1:0] fb_addr,
    input  logic [7:0]                fb_rdata,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic                      cmd_rs,
    output logic [1:0]                cmd_cs,
    output logic [7:0]                cmd_data
);
    import glcd_pkg::*;

    localparam logic [7:0] LINE_CMD = GLCD_SET_START | 8'(START_LINE % 64);

    glcd_state_e state_q, state_d;
    logic       valid_q, valid_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       init_q, init_d;

    logic       clr, set_chip, inc;
    logic [5:0] col;
    logic [2:0] page;
    logic       chip, page_wrap, frame_wrap;
    logic [7:0] rd_byte;

    glcd_addr_counter #(.PAGES(PAGES), .COLS(COLS)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .set_chip   (set_chip),
        .inc        (inc),
        .col        (col),
        .page       (page),
        .chip       (chip),
        .page_wrap  (page_wrap),
        .frame_wrap (frame_wrap)
    );

`ifdef GLCD_INVERT_EN
    assign rd_byte = fb_rdata ^ {8{invert}};
`else
    assign rd_byte = fb_rdata;
`endif

    // Instruction states raise valid on entry and drop it on transfer, so the
    // chip counter (and therefore cmd_cs) only moves while cmd_valid is low.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        rs_d     = rs_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        init_d   = init_q;
        clr      = 1'b0;
        set_chip = 1'b0;
        inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    clr     = 1'b1;
                    busy_d  = 1'b1;
                    state_d = init_q ? ST_SET_PAGE : ST_INIT_ON;
                end
            end
            ST_INIT_ON: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = GLCD_DISPLAY_ON;
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_INIT_LINE;
                end
            end
            ST_INIT_LINE: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = LINE_CMD;
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    if (!chip) begin
                        set_chip = 1'b1;
                        state_d  = ST_INIT_ON;
                    end else begin
                        clr     = 1'b1;
                        init_d  = 1'b1;
                        state_d = ST_SET_PAGE;
                    end
                end
            end
            ST_SET_PAGE: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = GLCD_SET_PAGE | {5'b0, page};
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_SET_COL;
                end
            end
            ST_SET_COL: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = GLCD_SET_COL;
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT_RD;
            ST_WAIT_RD: begin
                valid_d = 1'b1;
                rs_d    = 1'b1;
                data_d  = rd_byte;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (cmd_ready) begin
                    valid_d = 1'b0;
                    inc     = 1'b1;
                    if (frame_wrap) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (page_wrap) begin
                        state_d = ST_SET_PAGE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            init_q  <= init_d;
        end
    end

    assign fb_addr    = {chip, page, col};
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign cmd_valid  = valid_q;
    assign cmd_rs     = rs_q;
    assign cmd_cs     = chip ? 2'b10 : 2'b01;
    assign cmd_data   = data_q;

endmodule
